// File: rtl/ws2812b_decoder.sv
// WS2812B serial line decoder: recovers 24-bit GRB pixel words, frame gaps and bit errors.
// Define WS2812B_DECODER_STATS_EN to build the frame_pixels / err_count statistics registers.
module ws2812b_decoder #(
    parameter int THRESH_CYC   = 30,
    parameter int MIN_HIGH_CYC = 8,
    parameter int MAX_HIGH_CYC = 60,
    parameter int RESET_CYC    = 2500
) (
    input  logic        clk,
    input  logic        glbl_reset,
    input  logic        data_in,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_index,
    output logic        frame_done,
    output logic        bit_error,
    output logic [15:0] frame_pixels,
    output logic [7:0]  err_count
);

    localparam logic [15:0] THRESH   = 16'(THRESH_CYC);
    localparam logic [15:0] MIN_HIGH = 16'(MIN_HIGH_CYC);
    localparam logic [15:0] MAX_M1   = 16'(MAX_HIGH_CYC - 1);
    localparam logic [15:0] RESET_M1 = 16'(RESET_CYC - 1);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    logic [1:0]  sync_reg;
    logic        level_reg;
    logic        rise_reg;
    logic        fall_reg;

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic [4:0]  bit_cnt_reg;
    logic [23:0] shift_reg;
    logic [23:0] word_reg;
    logic        pix_pend_reg;
    logic        err_pend_reg;
    logic        done_pend_reg;
    logic        start_pend_reg;
    logic [7:0]  next_idx_reg;

    logic [15:0] cnt_inc;
    logic [23:0] shift_next;
    logic        pix_fire;

    assign cnt_inc    = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
    assign shift_next = {shift_reg[22:0], (cnt_reg >= THRESH)};
    assign pix_fire   = pix_pend_reg & ~err_pend_reg;

    // Synchronizer plus registered edge strobes aligned with the delayed level.
    always_ff @(posedge clk or posedge glbl_reset) begin
        if (glbl_reset) begin
            sync_reg  <= 2'b00;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], data_in};
            level_reg <= sync_reg[1];
            rise_reg  <= sync_reg[1] & ~level_reg;
            fall_reg  <= ~sync_reg[1] & level_reg;
        end
    end

    always_ff @(posedge clk or posedge glbl_reset) begin
        if (glbl_reset) begin
            state_reg      <= SYNC;
            cnt_reg        <= 16'd0;
            bit_cnt_reg    <= 5'd0;
            shift_reg      <= 24'd0;
            word_reg       <= 24'd0;
            pix_pend_reg   <= 1'b0;
            err_pend_reg   <= 1'b0;
            done_pend_reg  <= 1'b0;
            start_pend_reg <= 1'b0;
        end else begin
            pix_pend_reg   <= 1'b0;
            err_pend_reg   <= 1'b0;
            done_pend_reg  <= 1'b0;
            start_pend_reg <= 1'b0;
            case (state_reg)
                SYNC: begin
                    if (level_reg) begin
                        cnt_reg <= 16'd0;
                    end else if (cnt_reg == RESET_M1) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 16'd0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                IDLE: begin
                    if (rise_reg) begin
                        state_reg      <= HIGH;
                        cnt_reg        <= 16'd1;
                        bit_cnt_reg    <= 5'd0;
                        start_pend_reg <= 1'b1;
                    end
                end
                HIGH: begin
                    if (fall_reg) begin
                        if (cnt_reg < MIN_HIGH) begin
                            err_pend_reg <= 1'b1;
                            state_reg    <= SYNC;
                            cnt_reg      <= 16'd0;
                            bit_cnt_reg  <= 5'd0;
                        end else begin
                            shift_reg <= shift_next;
                            state_reg <= LOW;
                            cnt_reg   <= 16'd1;
                            if (bit_cnt_reg == 5'd23) begin
                                pix_pend_reg <= 1'b1;
                                word_reg     <= shift_next;
                                bit_cnt_reg  <= 5'd0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            end
                        end
                    end else if (cnt_reg == MAX_M1) begin
                        // This cycle is the MAX_HIGH_CYC-th high cycle.
                        err_pend_reg <= 1'b1;
                        state_reg    <= SYNC;
                        cnt_reg      <= 16'd0;
                        bit_cnt_reg  <= 5'd0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                LOW: begin
                    if (rise_reg) begin
                        state_reg <= HIGH;
                        cnt_reg   <= 16'd1;
                    end else if (cnt_reg == RESET_M1) begin
                        done_pend_reg <= 1'b1;
                        state_reg     <= IDLE;
                        cnt_reg       <= 16'd0;
                        bit_cnt_reg   <= 5'd0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: begin
                    state_reg <= SYNC;
                    cnt_reg   <= 16'd0;
                end
            endcase
        end
    end

    // Output stage: all strobes leave together, an error suppresses a pending pixel.
    always_ff @(posedge clk or posedge glbl_reset) begin
        if (glbl_reset) begin
            pixel_data   <= 24'd0;
            pixel_valid  <= 1'b0;
            pixel_index  <= 8'd0;
            frame_done   <= 1'b0;
            bit_error    <= 1'b0;
            next_idx_reg <= 8'd0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= err_pend_reg;
            if (start_pend_reg) begin
                pixel_index  <= 8'd0;
                next_idx_reg <= 8'd0;
            end
            if (pix_fire) begin
                pixel_data   <= word_reg;
                pixel_valid  <= 1'b1;
                pixel_index  <= next_idx_reg;
                next_idx_reg <= next_idx_reg + 8'd1;
            end
            if (done_pend_reg) begin
                frame_done   <= 1'b1;
                pixel_index  <= 8'd0;
                next_idx_reg <= 8'd0;
            end
        end
    end

`ifdef WS2812B_DECODER_STATS_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk or posedge glbl_reset) begin
        if (glbl_reset) begin
            frame_cnt_reg <= 16'd0;
            frame_pixels  <= 16'd0;
            err_count     <= 8'd0;
        end else begin
            if (start_pend_reg) begin
                frame_cnt_reg <= 16'd0;
            end else if (pix_fire && frame_cnt_reg != 16'hFFFF) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (done_pend_reg) begin
                frame_pixels  <= frame_cnt_reg;
                frame_cnt_reg <= 16'd0;
            end
            if (err_pend_reg && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    assign frame_pixels = 16'd0;
    assign err_count    = 8'd0;
`endif

endmodule

// File: doc/ws2812b_decoder.md
WS2812B_DECODER -- requirements
Module: ws2812b_decoder

Interface
REQ-001 SHALL have parameter THRESH_CYC, default 30: high-pulse length in clk cycles at or above which a bit decodes as 1 (0.6 us at 50 MHz).
REQ-002 SHALL have parameter MIN_HIGH_CYC, default 8: high pulses shorter than this are glitches and flag an error.
REQ-003 SHALL have parameter MAX_HIGH_CYC, default 60: a high level lasting this many cycles is a timeout error.
REQ-004 SHALL have parameter RESET_CYC, default 2500: a low level lasting this many cycles is a latch gap (50 us at 50 MHz).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic in this domain.
REQ-006 SHALL have port glbl_reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port data_in, input, 1 bit: asynchronous WS2812B serial line (strip DOUT or loopback of the driver wave_out).
REQ-008 SHALL have port pixel_data, output, 24 bits: last decoded GRB word; first received bit in bit 23.
REQ-009 SHALL have port pixel_valid, output, 1 bit: one-cycle strobe; pixel_data is updated on the same cycle.
REQ-010 SHALL have port pixel_index, output, 8 bits: position of pixel_data within the current frame, 0-based.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle strobe on a latch gap that follows at least one bit.
REQ-012 SHALL have port bit_error, output, 1 bit: one-cycle strobe on a glitch or timeout.
REQ-013 SHALL have port frame_pixels, output, 16 bits: pixel count of the last completed frame (statistics build only).
REQ-014 SHALL have port err_count, output, 8 bits: saturating count of bit_error strobes (statistics build only).

Function
REQ-015 SHALL pass data_in through a 2-flop synchronizer, then detect edges against a registered copy of the synchronized level.
REQ-016 SHALL implement states SYNC, IDLE, HIGH, LOW, with a 16-bit saturating level counter.
REQ-017 SYNC: counts low cycles and clears the count on any high; when the count reaches RESET_CYC it goes to IDLE; no strobes are issued in SYNC.
REQ-018 IDLE: on a rising edge it goes to HIGH with count=1 and the bit counter and pixel_index at 0.
REQ-019 HIGH, falling edge with count<MIN_HIGH_CYC: pulse bit_error, discard the partial pixel, go to SYNC.
REQ-020 HIGH, falling edge otherwise: shift in 1 if count>=THRESH_CYC, else 0; increment the bit counter; go to LOW with count=1.
REQ-021 HIGH, count reaching MAX_HIGH_CYC: pulse bit_error, discard the partial pixel, go to SYNC.
REQ-022 On the 24th shifted bit, SHALL load pixel_data, pulse pixel_valid, reset the bit counter to 0 and advance pixel_index on the following strobe.
REQ-023 Latency: pixel_valid SHALL rise exactly 4 clk cycles after the first clk edge that samples data_in low at the end of the 24th bit.
REQ-024 LOW, rising edge: go to HIGH with count=1.
REQ-025 LOW, count reaching RESET_CYC: pulse frame_done, discard any partial bits (no error), clear pixel_index, go to IDLE.
REQ-026 pixel_index SHALL wrap from 255 to 0.
REQ-027 If bit_error and the end of a pixel would coincide on the same cycle, bit_error wins and no pixel_valid is issued.
REQ-028 pixel_data SHALL hold its value between strobes.

Reset
REQ-029 glbl_reset SHALL force state SYNC and set all counters, pixel_data, pixel_index, strobes, frame_pixels and err_count to 0, taking effect immediately.
REQ-030 If reset is asserted mid-pixel, SHALL discard the partial data; after release, decoding resumes only after a full RESET_CYC low gap.

Configuration
REQ-031 Macro WS2812B_DECODER_STATS_EN defined: frame_pixels is loaded with the frame's pixel count at each frame_done, and err_count increments on each bit_error, saturating at 255.
REQ-032 Macro WS2812B_DECODER_STATS_EN undefined: frame_pixels and err_count SHALL be tied to 0 and no statistics registers are synthesized; ports are unchanged.

Verification (clk 50 MHz, default parameters)
REQ-033 Scenario: 3000 low cycles, then 24 bits encoding 0xFF00A5 (high 40/20 cycles, period 62) -> pixel_valid once, pixel_data=0xFF00A5, pixel_index=0.
REQ-034 Scenario: 120 pixels from the ws2812b_driver loopback, then a 2500-cycle low gap -> 120 pixel_valid strobes, last pixel_index=119, one frame_done, frame_pixels=120 with STATS_EN.
REQ-035 Scenario: a 5-cycle high glitch mid-pixel -> bit_error once, no pixel_valid, err_count=1; the next pixel decodes only after a 2500-cycle gap.
REQ-036 Scenario: data_in held high for 100 cycles -> bit_error at count 60, state SYNC.
REQ-037 Scenario: glbl_reset pulsed after 12 bits -> all outputs 0; a new full pixel 0x123456 sent after a gap decodes as 0x123456.
REQ-038 Scenario: high pulses of exactly 29 and 30 cycles -> decode as 0 and 1 respectively.
